// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - ID-stage interlock: load-use, mul/div occupancy and memory-wait stalls (optional stall counter via PIPE_STALL_CNT_EN)
module pipe_stall_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CW        = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_rn,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        id_mdstart,
    input  logic        id_mdread,
    input  logic        mem_wait,
    output logic        wpcir,
    output logic        id_bubble,
    output logic        wpipe,
    output logic        md_busy,
    output logic        md_done
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Remaining cycles the HI/LO unit stays occupied; zero means idle.
    logic [CW-1:0] mdcnt;

    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic mdh;
    logic stall;
    logic issue;

    // Hazard detection: a load in EX feeding a source of the ID instruction,
    // or an instruction that needs the mul/div unit while it is still busy.
    always_comb begin
        rs_hit  = id_use_rs & (id_rs == ex_rn);
        rt_hit  = id_use_rt & (id_rt == ex_rn);
        lu      = ex_wreg & ex_m2reg & (ex_rn != 5'd0) & (rs_hit | rt_hit);
        md_busy = (mdcnt != '0);
        mdh     = md_busy & (id_mdstart | id_mdread);
        stall   = lu | mdh;
        issue   = id_mdstart & ~stall & ~mem_wait;
    end

    // Enable generation: a memory wait freezes everything (no bubble),
    // otherwise a stall holds PC/IF-ID and injects one bubble into ID/EX.
    always_comb begin
        wpcir     = 1'b1;
        wpipe     = 1'b1;
        id_bubble = 1'b0;
        if (mem_wait) begin
            wpcir     = 1'b0;
            wpipe     = 1'b0;
        end else if (stall) begin
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end
    end

    // Occupancy countdown; keeps running through memory waits since the
    // mul/div unit is independent of the pipeline enables.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            mdcnt   <= '0;
            md_done <= 1'b0;
        end else begin
            if (issue) begin
                mdcnt <= MD_LOAD;
            end else if (mdcnt != '0) begin
                mdcnt <= mdcnt - CNT_ONE;
            end
            // An issue can only happen with mdcnt==0, so the 1->0 step is
            // never masked by a reload.
            md_done <= (mdcnt == CNT_ONE);
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Counts every cycle the front end did not advance (stall or freeze).
    always_ff @(posedge clk) begin
        if (!clrn) begin
            stall_cnt <= 32'd0;
        end else if (stall | mem_wait) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  id_rs, id_rt, ex_rn;
    logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
    logic        id_mdstart, id_mdread, mem_wait;
    logic        wpcir, id_bubble, wpipe, md_busy, md_done;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_CYCLES(M), .CW(8)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .id_mdstart(id_mdstart), .id_mdread(id_mdread), .mem_wait(mem_wait),
        .wpcir(wpcir), .id_bubble(id_bubble), .wpipe(wpipe),
        .md_busy(md_busy), .md_done(md_done)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: the cycle index of the last issue defines occupancy.
    int          cyc       = 0;
    int          issue_cyc = -100;
    logic [31:0] exp_cnt   = 32'd0;

    function automatic bit m_lu();
        return ex_wreg && ex_m2reg && (ex_rn != 0) &&
               ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));
    endfunction

    function automatic bit m_busy();
        return (cyc > issue_cyc) && (cyc <= issue_cyc + M);
    endfunction

    function automatic bit m_stall();
        return m_lu() || (m_busy() && (id_mdstart || id_mdread));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare against the model mid-cycle, then advance model and DUT one edge.
    task automatic tick();
        @(negedge clk);
        check("model_wpcir", wpcir, !mem_wait && !m_stall());
        check("model_wpipe", wpipe, !mem_wait);
        check("model_bubble", id_bubble, !mem_wait && m_stall());
        check("model_busy", md_busy, m_busy());
        check("model_done", md_done, cyc == issue_cyc + M + 1);
`ifdef PIPE_STALL_CNT_EN
        check("model_stall_cnt", stall_cnt, exp_cnt);
`endif
        @(posedge clk);
        if (!clrn) begin
            issue_cyc = -100;
            exp_cnt   = 32'd0;
        end else begin
            if (m_stall() || mem_wait) exp_cnt = exp_cnt + 32'd1;
            if (id_mdstart && !m_stall() && !mem_wait) issue_cyc = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rn = 0; ex_wreg = 0; ex_m2reg = 0;
        id_mdstart = 0; id_mdread = 0; mem_wait = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] ern;
        logic       wreg;
        logic       m2reg;
        logic       mw;
        logic       e_wpcir;
        logic       e_bubble;
        logic       e_wpipe;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{5'd31, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset held two cycles with id_mdstart asserted.
        idle();
        clrn = 0;
        id_mdstart = 1;
        @(posedge clk); #1;
        tick();
        tick();
        settle();
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        clrn = 1;
        id_mdstart = 0;
        settle();
        check("rst_wpcir", wpcir, 1);
        check("rst_wpipe", wpipe, 1);
        check("rst_bubble", id_bubble, 0);
        tick();

        // Combinational hazard table with the mul/div unit idle.
        for (int i = 0; i < 10; i++) begin
            id_rs = tbl[i].rs; id_rt = tbl[i].rt;
            id_use_rs = tbl[i].use_rs; id_use_rt = tbl[i].use_rt;
            ex_rn = tbl[i].ern; ex_wreg = tbl[i].wreg; ex_m2reg = tbl[i].m2reg;
            mem_wait = tbl[i].mw;
            settle();
            check($sformatf("tbl%0d_wpcir", i), wpcir, tbl[i].e_wpcir);
            check($sformatf("tbl%0d_bubble", i), id_bubble, tbl[i].e_bubble);
            check($sformatf("tbl%0d_wpipe", i), wpipe, tbl[i].e_wpipe);
            tick();
        end
        idle();
        tick();

        // Occupancy: issue at cycle 0, then a dependent mfhi waits it out.
        id_mdstart = 1;
        settle();
        check("md_issue_wpcir", wpcir, 1);
        tick();
        id_mdstart = 0;
        id_mdread = 1;
        for (int k = 1; k <= M; k++) begin
            settle();
            check($sformatf("md_c%0d_busy", k), md_busy, 1);
            check($sformatf("md_c%0d_wpcir", k), wpcir, 0);
            check($sformatf("md_c%0d_bubble", k), id_bubble, 1);
            check($sformatf("md_c%0d_done", k), md_done, 0);
            tick();
        end
        settle();
        check("md_c5_busy", md_busy, 0);
        check("md_c5_done", md_done, 1);
        check("md_c5_wpcir", wpcir, 1);
        tick();
        settle();
        check("md_c6_done", md_done, 0);
        idle();
        tick();

        // Memory wait outranks a load-use hazard; countdown keeps running.
        id_mdstart = 1;
        tick();
        id_mdstart = 0;
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 9; id_rs = 9; id_use_rs = 1;
        mem_wait = 1;
        for (int k = 1; k <= M; k++) begin
            settle();
            check($sformatf("prio_c%0d_wpcir", k), wpcir, 0);
            check($sformatf("prio_c%0d_wpipe", k), wpipe, 0);
            check($sformatf("prio_c%0d_bubble", k), id_bubble, 0);
            tick();
        end
        idle();
        settle();
        check("prio_done_after_wait", md_done, 1);
        check("prio_busy_after_wait", md_busy, 0);
        tick();

        // Back-to-back: second start issues in the md_done cycle and reloads.
        id_mdstart = 1;
        tick();
        for (int k = 1; k <= M; k++) begin
            settle();
            check($sformatf("b2b_c%0d_wpcir", k), wpcir, 0);
            tick();
        end
        settle();
        check("b2b_gap_busy", md_busy, 0);
        check("b2b_gap_done", md_done, 1);
        check("b2b_gap_wpcir", wpcir, 1);
        tick();
        id_mdstart = 0;
        for (int k = 1; k <= M; k++) begin
            settle();
            check($sformatf("b2b_re_c%0d_busy", k), md_busy, 1);
            tick();
        end
        settle();
        check("b2b_re_end_busy", md_busy, 0);
        check("b2b_re_end_done", md_done, 1);
        tick();

`ifdef PIPE_STALL_CNT_EN
        // 3 load-use stalls plus 5 memory-wait cycles from a fresh reset.
        clrn = 0;
        tick();
        clrn = 1;
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 2; id_rt = 2; id_use_rt = 1;
        for (int k = 0; k < 3; k++) tick();
        idle();
        mem_wait = 1;
        for (int k = 0; k < 5; k++) tick();
        mem_wait = 0;
        settle();
        check("cnt_eight", stall_cnt, 32'd8);
        clrn = 0;
        tick();
        clrn = 1;
        settle();
        check("cnt_reset", stall_cnt, 32'd0);
        tick();
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            clrn       = ($urandom_range(0, 59) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rn      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom);
            id_use_rt  = 1'($urandom);
            ex_wreg    = 1'($urandom);
            ex_m2reg   = 1'($urandom);
            id_mdstart = ($urandom_range(0, 3) == 0);
            id_mdread  = ($urandom_range(0, 3) == 0);
            mem_wait   = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
